// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 target for 16-bit {R/nW, addr[6:0], data[7:0]} frames backed by a register file
// Ports:
//   i_clock, i_reset_n       system clock, asynchronous active-low reset
//   SCLK, CS, MOSI, MISO     SPI pins (SCLK <= i_clock/8, CS active-low, MSB first)
//   o_reg_wr_en              one-cycle pulse when a write lands in the register file
//   o_reg_addr, o_reg_wdata  address / write data of the last committed frame
//   o_frame_done             one-cycle pulse per valid 16-bit frame
//   o_frame_error            one-cycle pulse per aborted or overlong frame
//   i_rd_addr, o_rd_data     local read port, 1-cycle registered latency
module spi_responder #(
  parameter int         NUM_REGS     = 16,
  parameter logic [6:0] WHOAMI_ADDR  = 7'h78,
  parameter logic [7:0] WHOAMI_VALUE = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  output logic       o_reg_wr_en,
  output logic [6:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_frame_done,
  output logic       o_frame_error,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_data
);
  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NR = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE_WAIT, IDLE, ADDR, DATA} state_t;

  state_t     r_state, w_next;
  logic [2:0] r_sclk_s, r_cs_s;
  logic [1:0] r_mosi_s;
  logic [4:0] r_cnt;
  logic [7:0] r_shift, r_tx;
  logic       r_rnw;
  logic [6:0] r_addr;
  logic [7:0] r_regs [NUM_REGS];

  logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_in_frame;
  logic       w_commit, w_commit_ok, w_commit_wr;
  logic [6:0] w_frame_addr;

  function automatic logic [7:0] f_lookup(input logic [6:0] a);
    return ({1'b0, a} < NR) ? r_regs[a[AW-1:0]] : (a == WHOAMI_ADDR) ? WHOAMI_VALUE : 8'h00;
  endfunction

  // stage [1] is the synchronised level, stage [2] the delayed copy for edge detection
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_sclk_s <= '0;
      r_cs_s   <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], SCLK};
      r_cs_s   <= {r_cs_s[1:0], CS};
      r_mosi_s <= {r_mosi_s[0], MOSI};
    end

  // SCLK activity only counts while the synchronised CS is low
  assign w_sclk_rise  = r_sclk_s[1] & ~r_sclk_s[2] & ~r_cs_s[1];
  assign w_sclk_fall  = ~r_sclk_s[1] & r_sclk_s[2] & ~r_cs_s[1];
  assign w_cs_rise    = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall    = ~r_cs_s[1] & r_cs_s[2];
  assign w_in_frame   = (r_state == ADDR) | (r_state == DATA);
  assign w_frame_addr = {r_shift[5:0], r_mosi_s[1]};
  assign w_commit     = w_in_frame & w_cs_rise;
  assign w_commit_ok  = w_commit & (r_cnt == 5'd16);
  assign w_commit_wr  = w_commit_ok & ~r_rnw & ({1'b0, r_addr} < NR);

  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE_WAIT;
    else            r_state <= w_next;

  // IDLE_WAIT only exits once CS is seen high, so a frame already running at reset release is dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE_WAIT: w_next = r_cs_s[1] ? IDLE : IDLE_WAIT;
      IDLE:      w_next = w_cs_fall ? ADDR : IDLE;
      ADDR:      w_next = w_cs_rise ? IDLE : (w_sclk_rise && r_cnt == 5'd7) ? DATA : ADDR;
      DATA:      w_next = w_cs_rise ? IDLE : DATA;
      default:   w_next = IDLE_WAIT;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit_wr) begin
      r_regs[r_addr[AW-1:0]] <= r_shift;
    end

  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_cnt         <= '0;
      r_shift       <= '0;
      r_tx          <= '0;
      r_rnw         <= 1'b0;
      r_addr        <= '0;
      o_reg_wr_en   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_error <= 1'b0;
      o_reg_addr    <= '0;
      o_reg_wdata   <= '0;
      o_rd_data     <= '0;
    end else begin
      o_reg_wr_en   <= w_commit_wr;
      o_frame_done  <= w_commit_ok;
      o_frame_error <= w_commit & (r_cnt != 5'd16);
      o_rd_data     <= f_lookup(i_rd_addr);
      if (w_commit_ok) o_reg_addr <= r_addr;
      if (w_commit_ok && !r_rnw) o_reg_wdata <= r_shift;
      // a CS fall wins over a coincident SCLK edge: that edge is not counted
      if (r_state == IDLE && w_cs_fall) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_tx    <= '0;
      end else if (w_commit) begin
        r_tx <= '0;
      end else if (w_in_frame && w_sclk_rise) begin
        r_shift <= {r_shift[6:0], r_mosi_s[1]};
        r_cnt   <= (r_cnt == 5'd17) ? r_cnt : r_cnt + 5'd1;
        if (r_state == ADDR && r_cnt == 5'd7) begin
          r_rnw  <= r_shift[6];
          r_addr <= w_frame_addr;
          r_tx   <= r_shift[6] ? f_lookup(w_frame_addr) : 8'h00;
        end
      end else if (r_state == DATA && w_sclk_fall && r_cnt != 5'd8) begin
        // the fall right after the 8th rise keeps the MSB so it is valid at the 9th rise
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end

  assign MISO = (r_state == DATA) & r_rnw & ~CS & r_tx[7];
endmodule
